// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller for a 4-digit common-anode display.
// Each slot presents one digit code, a one-hot digit select and a decimal point.
// Inputs are snapshotted once per frame so a displayed frame never tears, and
// leading zeros can be blanked.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   digits    in   [15:0] four digit codes, [3:0] = digit 0 (rightmost)
//   dp_in     in   [3:0]  decimal point request, bit k = digit k
//   blank_lz  in   1 = suppress leading zeros
//   val       out  [3:0] digit code for the 7-segment decoder
//   dig_sel   out  [3:0] one-hot active-high digit enable, 0000 = dark
//   dp        out  decimal point for the active digit
//   frame     out  one-cycle pulse at the start of each frame
module seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  val,
    output logic [3:0]  dig_sel,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned N_DIG     = 4;
    localparam int unsigned DIG_W     = NIB_W * N_DIG;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0]    presc_q,   presc_d;
    logic [1:0]       slot_q,    slot_d;
    logic [DIG_W-1:0] sh_dig_q,  sh_dig_d;
    logic [N_DIG-1:0] sh_dp_q,   sh_dp_d;
    logic             sh_blz_q,  sh_blz_d;
    logic [NIB_W-1:0] val_q,     val_d;
    logic [N_DIG-1:0] dig_sel_q, dig_sel_d;
    logic             dp_q,      dp_d;
    logic             frame_q,   frame_d;

    logic             tick;
    logic             boundary;
    logic [N_DIG-1:0] nib_idle;   // digit k shows nothing: nibble 0 and no dp
    logic [N_DIG-1:0] lead_idle;  // digits k..3 all idle
    logic             blank_nxt;
    logic [NIB_W-1:0] nib_nxt;

    // Prescaler, slot counter and frame-boundary shadow capture
    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        boundary  = tick && (slot_q == 2'd3);

        presc_d   = tick ? '0 : presc_q + PW'(1);
        slot_d    = tick ? slot_q + 2'd1 : slot_q;
        sh_dig_d  = sh_dig_q;
        sh_dp_d   = sh_dp_q;
        sh_blz_d  = sh_blz_q;
        frame_d   = boundary;

        if (boundary) begin
            sh_dig_d = digits;
            sh_dp_d  = dp_in;
            sh_blz_d = blank_lz;
        end
    end

    // Leading-zero detection on the shadow copy that the next slot will use
    always_comb begin
        nib_idle = '0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            nib_idle[i] = (sh_dig_d[i*NIB_W +: NIB_W] == '0) && !sh_dp_d[i];
        end
        lead_idle[3] = nib_idle[3];
        lead_idle[2] = nib_idle[2] && lead_idle[3];
        lead_idle[1] = nib_idle[1] && lead_idle[2];
        lead_idle[0] = nib_idle[0] && lead_idle[1];

        blank_nxt = sh_blz_d && (slot_d != 2'd0) && lead_idle[slot_d];

        case (slot_d)
            2'd0:    nib_nxt = sh_dig_d[3:0];
            2'd1:    nib_nxt = sh_dig_d[7:4];
            2'd2:    nib_nxt = sh_dig_d[11:8];
            default: nib_nxt = sh_dig_d[15:12];
        endcase
    end

    // Display registers reload only on tick edges, from the next slot
    always_comb begin
        val_d     = val_q;
        dig_sel_d = dig_sel_q;
        dp_d      = dp_q;

        if (tick) begin
            if (blank_nxt) begin
                val_d     = '0;
                dig_sel_d = '0;
                dp_d      = 1'b0;
            end else begin
                val_d     = nib_nxt;
                dig_sel_d = N_DIG'(1) << slot_d;
                dp_d      = sh_dp_d[slot_d];
            end
        end
    end

    // State registers; slot resets to 3 so the first tick is a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            slot_q    <= 2'd3;
            sh_dig_q  <= '0;
            sh_dp_q   <= '0;
            sh_blz_q  <= 1'b0;
            val_q     <= '0;
            dig_sel_q <= '0;
            dp_q      <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            slot_q    <= slot_d;
            sh_dig_q  <= sh_dig_d;
            sh_dp_q   <= sh_dp_d;
            sh_blz_q  <= sh_blz_d;
            val_q     <= val_d;
            dig_sel_q <= dig_sel_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign val     = val_q;
    assign dig_sel = dig_sel_q;
    assign dp      = dp_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: one instance with SCAN_DIV=4 and one with SCAN_DIV=1
// share the input stimulus. A cycle-count based reference model derives the
// expected display from the number of edges since reset release.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst4_n = 1'b1;
    logic        rst1_n = 1'b1;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [3:0]  val4, sel4, val1, sel1;
    logic        dp4, fr4, dp1, fr1;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // reference model state, index 0 = SCAN_DIV 4, index 1 = SCAN_DIV 1
    int          sd [2] = '{4, 1};
    bit          run_v [2];
    int          n_edge [2];
    logic [15:0] sh_dig [2];
    logic [3:0]  sh_dp [2];
    logic        sh_blz [2];

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .digits(digits), .dp_in(dp_in),
        .blank_lz(blank_lz), .val(val4), .dig_sel(sel4), .dp(dp4), .frame(fr4)
    );

    seg_scan #(.SCAN_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .digits(digits), .dp_in(dp_in),
        .blank_lz(blank_lz), .val(val1), .dig_sel(sel1), .dp(dp1), .frame(fr1)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs straight from the scan rules
    task automatic model_out(input int d, output logic [3:0] v, output logic [3:0] s,
                             output logic p, output logic f);
        int m, k;
        bit blank;
        logic [15:0] dg;
        v = 4'd0; s = 4'd0; p = 1'b0; f = 1'b0;
        if (run_v[d] && n_edge[d] >= sd[d]) begin
            m  = n_edge[d] / sd[d];
            k  = (m - 1) % 4;
            f  = (n_edge[d] % (4 * sd[d])) == sd[d];
            dg = sh_dig[d];
            blank = sh_blz[d] && (k >= 1);
            for (int i = k; i < 4; i++) begin
                if (((dg >> (4 * i)) & 16'hF) != 16'h0 || sh_dp[d][i]) blank = 1'b0;
            end
            if (!blank) begin
                s = 4'(1 << k);
                v = 4'((dg >> (4 * k)) & 16'hF);
                p = sh_dp[d][k];
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] v, s;
        logic p, f;
        model_out(0, v, s, p, f);
        check_eq("sd4.val", 16'(val4), 16'(v));
        check_eq("sd4.dig_sel", 16'(sel4), 16'(s));
        check_eq("sd4.dp", 16'(dp4), 16'(p));
        check_eq("sd4.frame", 16'(fr4), 16'(f));
        model_out(1, v, s, p, f);
        check_eq("sd1.val", 16'(val1), 16'(v));
        check_eq("sd1.dig_sel", 16'(sel1), 16'(s));
        check_eq("sd1.dp", 16'(dp1), 16'(p));
        check_eq("sd1.frame", 16'(fr1), 16'(f));
    endtask

    // One clock: advance model on the edge, check, return at the falling edge
    task automatic step_cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (run_v[d]) begin
                n_edge[d]++;
                if ((n_edge[d] % (4 * sd[d])) == sd[d]) begin
                    sh_dig[d] = digits;
                    sh_dp[d]  = dp_in;
                    sh_blz[d] = blank_lz;
                end
            end
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step_cycle();
    endtask

    task automatic set_in(input logic [15:0] dg, input logic [3:0] dpv, input logic blz);
        digits = dg; dp_in = dpv; blank_lz = blz;
    endtask

    task automatic model_reset(input int d);
        run_v[d] = 1'b0; n_edge[d] = 0;
        sh_dig[d] = '0; sh_dp[d] = '0; sh_blz[d] = 1'b0;
    endtask

    // Reset pulse mid-frame; outputs must clear before any clock edge
    task automatic pulse_reset(input int d);
        if (d == 0) rst4_n = 1'b0; else rst1_n = 1'b0;
        model_reset(d);
        #1;
        check_all();
        run(2);
        if (d == 0) rst4_n = 1'b1; else rst1_n = 1'b1;
        run_v[d] = 1'b1;
    endtask

    initial begin
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        model_reset(0);
        model_reset(1);
        set_in(16'h1234, 4'b0000, 1'b0);
        #1;
        rst4_n = 1'b0;
        rst1_n = 1'b0;
        #1;
        check_all();
        run(3);

        // release, basic scan, then no-tearing change mid-frame
        rst4_n = 1'b1; rst1_n = 1'b1;
        run_v[0] = 1'b1; run_v[1] = 1'b1;
        run(24);
        set_in(16'h5678, 4'b0000, 1'b0);
        run(40);

        // leading-zero and decimal-point cases
        set_in(16'h0007, 4'b0000, 1'b1); run(32);
        set_in(16'h0000, 4'b0000, 1'b1); run(32);
        set_in(16'h0105, 4'b0000, 1'b1); run(32);
        set_in(16'h0005, 4'b0010, 1'b1); run(32);
        set_in(16'hA0F0, 4'b0000, 1'b1); run(32);

        // SCAN_DIV=1 reset during slot 2 (after edge n, slot = (n-1)%4)
        for (int i = 0; i < 8 && (n_edge[1] % 4) != 3; i++) step_cycle();
        pulse_reset(1);
        run(12);

        // randomized inputs with occasional mid-frame resets
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_in(16'($urandom) & masks[$urandom_range(0, 4)],
                       ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                       1'($urandom));
            end
            if (i % 200 == 100 && (n_edge[1] % 4) == 3) pulse_reset(1);
            else if (i % 300 == 150) pulse_reset(0);
            else step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed display scan controller for the stopwatch's 4-digit common-anode display. It sits directly upstream of the 7-segment decoder. Each scan slot it presents one 4-bit digit code on `val` for the decoder, plus a one-hot digit select and a decimal-point bit. It also snapshots the stopwatch's digit word once per frame so a displayed frame never tears, and optionally blanks leading zeros.

## Interface
- `SCAN_DIV`, default 50000 — clock cycles per digit slot; legal range ≥1; prescaler width is `$clog2(SCAN_DIV)`, minimum 1 bit.
- `clk` in 1 — system clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `digits` in 16 — four digit codes; `[3:0]` is digit 0 (rightmost) … `[15:12]` is digit 3 (leftmost).
- `dp_in` in 4 — decimal point request per digit; bit k belongs to digit k.
- `blank_lz` in 1 — 1 enables leading-zero suppression.
- `val` out 4 — digit code to the decoder.
- `dig_sel` out 4 — one-hot active-high digit enable; all-zero means the display is dark.
- `dp` out 1 — decimal point for the active digit.
- `frame` out 1 — one-cycle pulse marking the start of a new frame.

## Operation
- **Prescaler `presc`:** counts 0..SCAN_DIV-1 and wraps to 0. `tick` = (`presc` == SCAN_DIV-1). With SCAN_DIV=1, `tick` is permanently 1.
- **Slot counter `slot`** (2 bits): advances on `tick`, with 3→0 wrap. Slot k drives digit k. Scan order is 0,1,2,3.
- **Frame boundary** (`tick` with `slot`==3), on the same edge:
  - `digits`, `dp_in` and `blank_lz` are captured into shadow registers.
  - `slot`→0.
  - `frame` is asserted for the following cycle.
- **Shadow use:** inputs are sampled only at the frame boundary. Changes mid-frame have no effect until the next boundary.
- **Blank rule:** from the shadow copy, digit k is blanked iff all of the following hold:
  - `blank_lz`=1;
  - k≥1;
  - nibbles k..3 are all 0;
  - `dp_in` bits k..3 are all 0.
  - Digit 0 is never blanked.
- **Displayed slot:** `dig_sel` = one-hot(k), `val` = shadow nibble k, `dp` = shadow `dp_in[k]`.
- **Blanked slot:** `dig_sel`=0000, `val`=0, `dp`=0.
- **Non-BCD codes:** nibbles A–F pass through unchanged; the decoder renders them. A nonzero hex nibble counts as non-zero for blanking.
- **Output registering:** `val`, `dig_sel` and `dp` are registers. They are loaded on every `tick` edge from the next-slot value. At a frame boundary they use the newly captured shadow data, so slot 0 of a new frame already shows new data.
- **Reset values** (asynchronous, immediate, including mid-frame):
  - `presc`=0, `slot`=3, shadow registers all 0;
  - `val`=0, `dig_sel`=0000, `dp`=0, `frame`=0.
  - The display stays dark until the first frame boundary.

## Timing
- Slot duration is exactly SCAN_DIV cycles; frame period is 4·SCAN_DIV cycles. `frame` pulses are 4·SCAN_DIV apart.
- After `rst_n` rises, the first `tick` occurs on the SCAN_DIV-th rising edge. That edge captures the inputs and drives slot 0. `frame` is high during the following cycle.
- `val`, `dig_sel` and `dp` change only on `tick` edges and are stable for the whole slot. Exactly one `dig_sel` bit is set, or none for a blanked slot. No cycle exists with two bits set.
- Input-to-display latency: up to 4·SCAN_DIV cycles (wait for the frame boundary), plus 0 further cycles at the boundary.
- Asserting `rst_n` low mid-slot forces the reset values asynchronously. On release, scanning restarts from the first-boundary sequence above.

## Test plan
All scenarios use SCAN_DIV=4 unless noted.
- **Reset:** hold `rst_n`=0 → `dig_sel`=0000, `val`=0, `dp`=0, `frame`=0. Release → dark for 3 cycles. The 4th edge gives `dig_sel`=0001, and `frame`=1 for one cycle.
- **Basic scan:** `digits`=16'h1234, `dp_in`=0, `blank_lz`=0 → `val` sequence 4,3,2,1 with `dig_sel` 0001,0010,0100,1000, each held 4 cycles. `frame` pulses every 16 cycles.
- **No tearing:** change `digits` from 16'h1234 to 16'h5678 during slot 1 → slots 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5.
- **Leading zeros:** with `blank_lz`=1:
  - `digits`=16'h0007 → slot 0 shows 7 with `dig_sel`=0001; slots 1–3 have `dig_sel`=0000.
  - `digits`=16'h0000 → only slot 0 is lit, `val`=0.
  - `digits`=16'h0105 → slot 3 dark; slots 2,1,0 show 1,0,5.
- **Decimal point vs blanking:** `digits`=16'h0005, `dp_in`=4'b0010, `blank_lz`=1 → slot 1 lit with `val`=0 and `dp`=1; slot 0 shows 5 with `dp`=0; slots 2–3 dark.
- **SCAN_DIV=1 plus reset mid-frame:** slot advances every cycle and `frame` pulses every 4 cycles. Pulsing `rst_n` low during slot 2 clears outputs immediately. After release, slot 0 appears on the 1st edge.
